// File: rtl/in_service_controller_pkg.sv
// Shared definitions for the 8259A-compatible in-service controller:
// OCW2 command codes, INTA sequence states and data-bus byte selects.
package in_service_controller_pkg;

    localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
    localparam logic [2:0] OCW2_S_EOI      = 3'b011;
    localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
    localparam logic [2:0] OCW2_ROT_S_EOI  = 3'b111;
    localparam logic [2:0] OCW2_SET_PRIO   = 3'b110;

    localparam logic [1:0] SEL_CALL = 2'b00;
    localparam logic [1:0] SEL_LOW  = 2'b01;
    localparam logic [1:0] SEL_HIGH = 2'b10;

    localparam logic [2:0] DEFAULT_ROTATE = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        ACK2,
        ACK3
    } ack_state_t;

    // Binary level of a one-hot vector; 0 when the vector is empty.
    function automatic logic [2:0] level_of(input logic [7:0] onehot);
        level_of = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) level_of = 3'(i);
        end
    endfunction

endpackage

// File: rtl/in_service_priority_encoder.sv
// Picks the highest-priority set ISR bit; IR(rotate+1) is highest and the
// search wraps upward, so IR(rotate) itself is lowest.
module in_service_priority_encoder (
    input  logic [7:0] isr,
    input  logic [2:0] rotate,
    output logic [7:0] highest
);

    always_comb begin
        // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
        highest = '0;
        // Walk from lowest to highest priority; the last hit wins.
        for (int i = 8; i >= 1; i--) begin
            if (isr[3'(rotate + 3'(i))]) begin
                highest = 8'(1) << 3'(rotate + 3'(i));
            end
        end
    end

endmodule

// File: rtl/in_service_controller.sv
// INTA acknowledge sequencer with In-Service Register, OCW2 EOI/rotate
// handling and automatic EOI; sits downstream of the priority resolver.
module in_service_controller
    import in_service_controller_pkg::*;
#(
    parameter logic [2:0] RESET_ROTATE = DEFAULT_ROTATE
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt,
    input  logic       interrupt_ack_n,
    input  logic       mode_8086,
    input  logic       auto_eoi,
    input  logic       auto_rotate,
    input  logic       eoi_valid,
    input  logic [2:0] eoi_cmd,
    input  logic [2:0] eoi_level,
    output logic       interrupt_out,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [2:0] priority_rotate,
    output logic [7:0] clear_interrupt_request,
    output logic [2:0] acknowledged_level,
    output logic       data_drive_enable,
    output logic [1:0] data_byte_select,
    output logic       end_of_ack
);

    ack_state_t state;
    logic       inta_low_prev;
    logic       spurious;
    logic       fall;
    logic       rise;
    logic       final_rise;
    logic [7:0] isr_set;
    logic [7:0] isr_clear;
    logic [2:0] rotate_next;

    // The edge register holds "INTA was low"; reset loads 1 so INTA held low
    // across reset release is not seen as a new falling edge.
    assign fall       = !interrupt_ack_n && !inta_low_prev;
    assign rise       = interrupt_ack_n && inta_low_prev;
    assign final_rise = rise && ((state == ACK2 && mode_8086) || state == ACK3);

    in_service_priority_encoder u_encoder (
        .isr     (in_service_register),
        .rotate  (priority_rotate),
        .highest (highest_level_in_service)
    );

    always_comb begin
        isr_set     = '0;
        isr_clear   = '0;
        rotate_next = priority_rotate;
        if (state == IDLE && fall) isr_set = interrupt;
        if (final_rise && auto_eoi && !spurious) begin
            isr_clear = 8'(1) << acknowledged_level;
            if (auto_rotate) rotate_next = acknowledged_level;
        end
        // OCW2 is evaluated after AEOI so its rotate takes precedence.
        if (eoi_valid) begin
            case (eoi_cmd)
                OCW2_NS_EOI: isr_clear = isr_clear | highest_level_in_service;
                OCW2_S_EOI:  isr_clear = isr_clear | (8'(1) << eoi_level);
                OCW2_ROT_NS_EOI: begin
                    if (|highest_level_in_service) begin
                        isr_clear   = isr_clear | highest_level_in_service;
                        rotate_next = level_of(highest_level_in_service);
                    end
                end
                OCW2_ROT_S_EOI: begin
                    isr_clear   = isr_clear | (8'(1) << eoi_level);
                    rotate_next = eoi_level;
                end
                OCW2_SET_PRIO: rotate_next = eoi_level;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state                   <= IDLE;
            inta_low_prev           <= 1'b1;
            spurious                <= 1'b0;
            in_service_register     <= '0;
            priority_rotate         <= RESET_ROTATE;
            interrupt_out           <= 1'b0;
            clear_interrupt_request <= '0;
            acknowledged_level      <= '0;
            data_drive_enable       <= 1'b0;
            data_byte_select        <= SEL_CALL;
            end_of_ack              <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            inta_low_prev           <= !interrupt_ack_n;
            in_service_register     <= (in_service_register & ~isr_clear) | isr_set;
            priority_rotate         <= rotate_next;
            clear_interrupt_request <= '0;
            end_of_ack              <= 1'b0;
            interrupt_out           <= (state == IDLE && !fall) ? |interrupt : 1'b0;
            if (rise) begin
                data_drive_enable <= 1'b0;
                data_byte_select  <= SEL_CALL;
            end
            case (state)
                IDLE: if (fall) begin
                    clear_interrupt_request <= interrupt;
                    acknowledged_level      <= (|interrupt) ? level_of(interrupt) : 3'd7;
                    spurious                <= ~|interrupt;
                    data_drive_enable       <= !mode_8086;
                    data_byte_select        <= SEL_CALL;
                    state                   <= ACK1;
                end
                ACK1: if (fall) begin
                    data_drive_enable <= 1'b1;
                    data_byte_select  <= SEL_LOW;
                    state             <= ACK2;
                end
                ACK2: begin
                    if (fall && !mode_8086) begin
                        data_drive_enable <= 1'b1;
                        data_byte_select  <= SEL_HIGH;
                        state             <= ACK3;
                    end else if (final_rise) begin
                        end_of_ack <= 1'b1;
                        state      <= IDLE;
                    end
                end
                ACK3: if (final_rise) begin
                    end_of_ack <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_in_service_controller.sv
// Directed bench for in_service_controller: hand-written INTA sequences plus
// a table of acknowledge/OCW2 operations with expected ISR and rotation.
module tb_in_service_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] interrupt;
    logic       interrupt_ack_n;
    logic       mode_8086;
    logic       auto_eoi;
    logic       auto_rotate;
    logic       eoi_valid;
    logic [2:0] eoi_cmd;
    logic [2:0] eoi_level;
    logic       interrupt_out;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [2:0] priority_rotate;
    logic [7:0] clear_interrupt_request;
    logic [2:0] acknowledged_level;
    logic       data_drive_enable;
    logic [1:0] data_byte_select;
    logic       end_of_ack;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic       is_ack;
        logic [7:0] irq;
        logic [2:0] cmd;
        logic [2:0] level;
        logic [7:0] exp_isr;
        logic [2:0] exp_rot;
        logic [7:0] exp_high;
    } vec_t;

    vec_t vecs[15];

    in_service_controller dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .interrupt                (interrupt),
        .interrupt_ack_n          (interrupt_ack_n),
        .mode_8086                (mode_8086),
        .auto_eoi                 (auto_eoi),
        .auto_rotate              (auto_rotate),
        .eoi_valid                (eoi_valid),
        .eoi_cmd                  (eoi_cmd),
        .eoi_level                (eoi_level),
        .interrupt_out            (interrupt_out),
        .in_service_register      (in_service_register),
        .highest_level_in_service (highest_level_in_service),
        .priority_rotate          (priority_rotate),
        .clear_interrupt_request  (clear_interrupt_request),
        .acknowledged_level       (acknowledged_level),
        .data_drive_enable        (data_drive_enable),
        .data_byte_select         (data_byte_select),
        .end_of_ack               (end_of_ack)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic do_ack(input logic [7:0] irq);
        interrupt       = irq;
        interrupt_ack_n = 1'b0;
        step();
        interrupt       = 8'h00;
        interrupt_ack_n = 1'b1;
        step();
        interrupt_ack_n = 1'b0;
        step();
        interrupt_ack_n = 1'b1;
        step();
        step();
    endtask

    task automatic do_eoi(input logic [2:0] cmd, input logic [2:0] level);
        eoi_valid = 1'b1;
        eoi_cmd   = cmd;
        eoi_level = level;
        step();
        eoi_valid = 1'b0;
        step();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h02, 3'd0, 3'd0, 8'h02, 3'd7, 8'h02};
        vecs[1]  = '{1'b1, 8'h20, 3'd0, 3'd0, 8'h22, 3'd7, 8'h02};
        vecs[2]  = '{1'b0, 8'h00, 3'b001, 3'd0, 8'h20, 3'd7, 8'h20};
        vecs[3]  = '{1'b0, 8'h00, 3'b101, 3'd0, 8'h00, 3'd5, 8'h00};
        vecs[4]  = '{1'b0, 8'h00, 3'b101, 3'd0, 8'h00, 3'd5, 8'h00};
        vecs[5]  = '{1'b0, 8'h00, 3'b110, 3'd3, 8'h00, 3'd3, 8'h00};
        vecs[6]  = '{1'b1, 8'h01, 3'd0, 3'd0, 8'h01, 3'd3, 8'h01};
        vecs[7]  = '{1'b1, 8'h80, 3'd0, 3'd0, 8'h81, 3'd3, 8'h80};
        vecs[8]  = '{1'b0, 8'h00, 3'b011, 3'd7, 8'h01, 3'd3, 8'h01};
        vecs[9]  = '{1'b0, 8'h00, 3'b111, 3'd0, 8'h00, 3'd0, 8'h00};
        vecs[10] = '{1'b1, 8'h10, 3'd0, 3'd0, 8'h10, 3'd0, 8'h10};
        vecs[11] = '{1'b0, 8'h00, 3'b010, 3'd4, 8'h10, 3'd0, 8'h10};
        vecs[12] = '{1'b0, 8'h00, 3'b100, 3'd4, 8'h10, 3'd0, 8'h10};
        vecs[13] = '{1'b0, 8'h00, 3'b111, 3'd4, 8'h00, 3'd4, 8'h00};
        vecs[14] = '{1'b0, 8'h00, 3'b110, 3'd7, 8'h00, 3'd7, 8'h00};

        reset_n = 1'b0; interrupt = 8'h00; interrupt_ack_n = 1'b1;
        mode_8086 = 1'b1; auto_eoi = 1'b0; auto_rotate = 1'b0;
        eoi_valid = 1'b0; eoi_cmd = 3'd0; eoi_level = 3'd0;
        step(); step();
        check("reset isr", in_service_register, 8'h00);
        check("reset rotate", 8'(priority_rotate), 8'h07);
        check("reset highest", highest_level_in_service, 8'h00);
        check("reset int_out", 8'(interrupt_out), 8'h00);
        check("reset drive", 8'(data_drive_enable), 8'h00);
        reset_n = 1'b1;
        step();

        // 8086 two-pulse sequence on IR2.
        interrupt = 8'h04;
        step();
        check("8086 int_out idle", 8'(interrupt_out), 8'h01);
        interrupt_ack_n = 1'b0;
        step();
        check("8086 clear pulse", clear_interrupt_request, 8'h04);
        check("8086 isr set", in_service_register, 8'h04);
        check("8086 level", 8'(acknowledged_level), 8'h02);
        check("8086 int_out p1", 8'(interrupt_out), 8'h00);
        check("8086 no drive p1", 8'(data_drive_enable), 8'h00);
        interrupt = 8'h00;
        step();
        check("8086 clear one cycle", clear_interrupt_request, 8'h00);
        interrupt_ack_n = 1'b1;
        step();
        check("8086 no eoa p1", 8'(end_of_ack), 8'h00);
        interrupt = 8'h04;
        interrupt_ack_n = 1'b0;
        step();
        check("8086 drive p2", 8'(data_drive_enable), 8'h01);
        check("8086 select p2", 8'(data_byte_select), 8'h01);
        check("8086 int_out p2", 8'(interrupt_out), 8'h00);
        interrupt_ack_n = 1'b1;
        step();
        check("8086 end_of_ack", 8'(end_of_ack), 8'h01);
        check("8086 drive off", 8'(data_drive_enable), 8'h00);
        check("8086 int_out at eoa", 8'(interrupt_out), 8'h00);
        step();
        check("8086 eoa one cycle", 8'(end_of_ack), 8'h00);
        check("8086 int_out after", 8'(interrupt_out), 8'h01);
        check("8086 isr held", in_service_register, 8'h04);
        interrupt = 8'h00;
        do_eoi(3'b011, 3'd2);
        check("8086 specific eoi", in_service_register, 8'h00);

        // 8080 three-pulse sequence on IR0.
        mode_8086 = 1'b0;
        interrupt = 8'h01;
        interrupt_ack_n = 1'b0;
        step();
        check("8080 drive p1", 8'(data_drive_enable), 8'h01);
        check("8080 select p1", 8'(data_byte_select), 8'h00);
        check("8080 level", 8'(acknowledged_level), 8'h00);
        check("8080 isr", in_service_register, 8'h01);
        interrupt = 8'h00;
        interrupt_ack_n = 1'b1;
        step();
        check("8080 drive off p1", 8'(data_drive_enable), 8'h00);
        interrupt_ack_n = 1'b0;
        step();
        check("8080 select p2", 8'(data_byte_select), 8'h01);
        interrupt_ack_n = 1'b1;
        step();
        check("8080 no eoa p2", 8'(end_of_ack), 8'h00);
        interrupt_ack_n = 1'b0;
        step();
        check("8080 drive p3", 8'(data_drive_enable), 8'h01);
        check("8080 select p3", 8'(data_byte_select), 8'h02);
        interrupt_ack_n = 1'b1;
        step();
        check("8080 end_of_ack", 8'(end_of_ack), 8'h01);
        step();
        do_eoi(3'b001, 3'd0);
        check("8080 ns eoi", in_service_register, 8'h00);
        mode_8086 = 1'b1;

        // Spurious acknowledge; AEOI rotate must not fire for it.
        auto_eoi = 1'b1; auto_rotate = 1'b1;
        interrupt = 8'h00;
        interrupt_ack_n = 1'b0;
        step();
        check("spurious level", 8'(acknowledged_level), 8'h07);
        check("spurious isr", in_service_register, 8'h00);
        check("spurious clear", clear_interrupt_request, 8'h00);
        interrupt_ack_n = 1'b1; step();
        interrupt_ack_n = 1'b0; step();
        interrupt_ack_n = 1'b1; step();
        check("spurious eoa", 8'(end_of_ack), 8'h01);
        check("spurious rotate", 8'(priority_rotate), 8'h07);
        step();
        auto_eoi = 1'b0; auto_rotate = 1'b0;

        // Table of acknowledges and OCW2 commands.
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_ack) do_ack(vecs[i].irq);
            else do_eoi(vecs[i].cmd, vecs[i].level);
            check($sformatf("vec%0d isr", i), in_service_register, vecs[i].exp_isr);
            check($sformatf("vec%0d rotate", i), 8'(priority_rotate), 8'(vecs[i].exp_rot));
            check($sformatf("vec%0d highest", i), highest_level_in_service, vecs[i].exp_high);
        end

        // AEOI with auto rotate on IR3.
        auto_eoi = 1'b1; auto_rotate = 1'b1;
        interrupt = 8'h08;
        interrupt_ack_n = 1'b0; step();
        check("aeoi isr mid", in_service_register, 8'h08);
        interrupt = 8'h00;
        interrupt_ack_n = 1'b1; step();
        interrupt_ack_n = 1'b0; step();
        interrupt_ack_n = 1'b1; step();
        check("aeoi eoa", 8'(end_of_ack), 8'h01);
        check("aeoi isr cleared", in_service_register, 8'h00);
        check("aeoi rotate", 8'(priority_rotate), 8'h03);
        step();

        // AEOI rotate coinciding with OCW2 set-priority: OCW2 wins.
        interrupt = 8'h20;
        interrupt_ack_n = 1'b0; step();
        interrupt = 8'h00;
        interrupt_ack_n = 1'b1; step();
        interrupt_ack_n = 1'b0; step();
        interrupt_ack_n = 1'b1;
        eoi_valid = 1'b1; eoi_cmd = 3'b110; eoi_level = 3'd6;
        step();
        eoi_valid = 1'b0;
        check("coincide rotate", 8'(priority_rotate), 8'h06);
        check("coincide isr", in_service_register, 8'h00);
        step();
        auto_eoi = 1'b0; auto_rotate = 1'b0;
        do_eoi(3'b110, 3'd7);

        // Set and clear of the same bit in one cycle: set wins.
        do_ack(8'h01);
        interrupt = 8'h01;
        interrupt_ack_n = 1'b0;
        eoi_valid = 1'b1; eoi_cmd = 3'b011; eoi_level = 3'd0;
        step();
        check("set wins isr", in_service_register, 8'h01);
        eoi_valid = 1'b0; interrupt = 8'h00;
        interrupt_ack_n = 1'b1; step();
        interrupt_ack_n = 1'b0;
        eoi_valid = 1'b1; eoi_cmd = 3'b001;
        step();
        eoi_valid = 1'b0;
        check("eoi during ack isr", in_service_register, 8'h00);
        check("eoi during ack select", 8'(data_byte_select), 8'h01);
        interrupt_ack_n = 1'b1; step();
        check("eoi during ack eoa", 8'(end_of_ack), 8'h01);
        step();

        // Reset in ACK1 with INTA held low through release.
        do_eoi(3'b110, 3'd2);
        interrupt = 8'h04;
        interrupt_ack_n = 1'b0; step();
        check("pre-reset isr", in_service_register, 8'h04);
        reset_n = 1'b0; step();
        check("mid reset isr", in_service_register, 8'h00);
        check("mid reset rotate", 8'(priority_rotate), 8'h07);
        check("mid reset level", 8'(acknowledged_level), 8'h00);
        interrupt = 8'h08;
        reset_n = 1'b1; step(); step();
        check("post reset isr", in_service_register, 8'h00);
        check("post reset clear", clear_interrupt_request, 8'h00);
        check("post reset int_out", 8'(interrupt_out), 8'h01);
        check("post reset drive", 8'(data_drive_enable), 8'h00);
        interrupt_ack_n = 1'b1; step(); step();
        check("post reset no eoa", 8'(end_of_ack), 8'h00);
        interrupt_ack_n = 1'b0; step();
        check("post reset new ack", in_service_register, 8'h08);
        check("post reset new level", 8'(acknowledged_level), 8'h03);
        interrupt_ack_n = 1'b1; step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
